// File: rtl/seg_pkg.sv
// Shared constants, types and helpers for the seven-segment bus capture block.
package seg_pkg;

    // Active-low segment codes {dp,g,f,e,d,c,b,a}; dp is off (1) in every constant.
    localparam logic [7:0] SEG_0 = 8'hC0;
    localparam logic [7:0] SEG_1 = 8'hF9;
    localparam logic [7:0] SEG_2 = 8'hA4;
    localparam logic [7:0] SEG_3 = 8'hB0;
    localparam logic [7:0] SEG_4 = 8'h99;
    localparam logic [7:0] SEG_5 = 8'h92;
    localparam logic [7:0] SEG_6 = 8'h82;
    localparam logic [7:0] SEG_7 = 8'hF8;
    localparam logic [7:0] SEG_8 = 8'h80;
    localparam logic [7:0] SEG_9 = 8'h90;
    localparam logic [7:0] SEG_A = 8'h88;
    localparam logic [7:0] SEG_B = 8'h83;
    localparam logic [7:0] SEG_C = 8'hC6;
    localparam logic [7:0] SEG_D = 8'hA1;
    localparam logic [7:0] SEG_E = 8'h86;
    localparam logic [7:0] SEG_F = 8'h8E;

    localparam logic [5:0] SEL_STATIC = 6'h00;
    localparam logic [5:0] SEL_BLANK  = 6'h3F;

    typedef enum logic [1:0] {IDLE, FILTER, COMMIT, HOLD} state_t;

    typedef struct packed {
        logic [5:0] sel;
        logic [7:0] led;
    } seg_pair_t;

    // Active-low select to {valid, digit mask}: one low bit or static mode are legal.
    function automatic logic [6:0] sel_decode(input logic [5:0] sel);
        logic [6:0] res;
        res = 7'd0;
        if (sel == SEL_STATIC)
            res = {1'b1, 6'h3F};
        else if ($countones(~sel) == 1)
            res = {1'b1, ~sel};
        return res;
    endfunction

endpackage

// File: rtl/seg_pattern_dec.sv
// Combinational 7-bit active-low segment pattern to hex nibble decoder.
module seg_pattern_dec
    import seg_pkg::*;
(
    input  logic [6:0] i_pat,
    output logic       o_valid,
    output logic [3:0] o_nibble
);

    // Exact match against the 16 hex glyphs; anything else is illegal.
    always_comb begin
        o_valid  = 1'b1;
        o_nibble = 4'h0;
        case (i_pat)
            SEG_0[6:0]: o_nibble = 4'h0;
            SEG_1[6:0]: o_nibble = 4'h1;
            SEG_2[6:0]: o_nibble = 4'h2;
            SEG_3[6:0]: o_nibble = 4'h3;
            SEG_4[6:0]: o_nibble = 4'h4;
            SEG_5[6:0]: o_nibble = 4'h5;
            SEG_6[6:0]: o_nibble = 4'h6;
            SEG_7[6:0]: o_nibble = 4'h7;
            SEG_8[6:0]: o_nibble = 4'h8;
            SEG_9[6:0]: o_nibble = 4'h9;
            SEG_A[6:0]: o_nibble = 4'hA;
            SEG_B[6:0]: o_nibble = 4'hB;
            SEG_C[6:0]: o_nibble = 4'hC;
            SEG_D[6:0]: o_nibble = 4'hD;
            SEG_E[6:0]: o_nibble = 4'hE;
            SEG_F[6:0]: o_nibble = 4'hF;
            default:    o_valid  = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_led_capture.sv
// Seven-segment bus capture: filters the scanned (sel, led) bus, decodes each
// stable pattern and assembles a six-digit frame with per-digit dp.
// Optional build macro SEG_CAPTURE_ERR_CNT_EN adds a saturating err_cnt output.
module seg_led_capture
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [5:0]  seg_sel,
    input  logic [7:0]  seg_led,
    output logic [23:0] data_out,
    output logic [5:0]  dp_out,
    output logic        data_valid,
    output logic        decode_err
`ifdef SEG_CAPTURE_ERR_CNT_EN
   ,output logic [7:0]  err_cnt
`endif
);

    seg_pair_t        r_sample, r_cand, w_cand_nx;
    state_t           r_state, w_state_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx;

    logic [5:0][3:0]  r_shadow, w_shadow_nx, r_data_out;
    logic [5:0]       r_dp_shadow, w_dp_nx, r_dp_out;
    logic [5:0]       r_seen, w_seen_nx;
    logic             r_data_valid, r_decode_err;

    logic             w_same, w_blank;
    logic             w_pat_valid;
    logic [3:0]       w_nibble;
    logic [6:0]       w_sel_info;
    logic [5:0]       w_mask;
    logic             w_commit_ok, w_commit_bad;

    // Single register stage on the bus; it is already in the sys_clk domain.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) r_sample <= '0;
        else         r_sample <= {seg_sel, seg_led};
    end

    // FSM state, candidate pair and stability counter.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= IDLE;
            r_cand  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cand  <= w_cand_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    assign w_same  = (r_sample == r_cand);
    assign w_blank = (r_sample.sel == SEL_BLANK);

    // Next state: a pair must stay put STABLE_CYCLES samples, then commits once.
    always_comb begin
        w_state_nx = r_state;
        w_cand_nx  = r_cand;
        w_cnt_nx   = r_cnt;
        case (r_state)
            IDLE: begin
                if (!w_blank) begin
                    w_cand_nx  = r_sample;
                    w_cnt_nx   = CNT_W'(1);
                    w_state_nx = FILTER;
                end
            end
            FILTER: begin
                if (!w_same) begin
                    if (w_blank) begin
                        w_state_nx = IDLE;
                    end else begin
                        w_cand_nx = r_sample;
                        w_cnt_nx  = CNT_W'(1);
                    end
                end else if (r_cnt == CNT_W'(STABLE_CYCLES - 1)) begin
                    w_state_nx = COMMIT;
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                end
            end
            COMMIT: w_state_nx = HOLD;
            HOLD: begin
                if (!w_same) begin
                    if (w_blank) begin
                        w_state_nx = IDLE;
                    end else begin
                        w_cand_nx  = r_sample;
                        w_cnt_nx   = CNT_W'(1);
                        w_state_nx = FILTER;
                    end
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    seg_pattern_dec u_dec (
        .i_pat    (r_cand.led[6:0]),
        .o_valid  (w_pat_valid),
        .o_nibble (w_nibble)
    );

    assign w_sel_info   = sel_decode(r_cand.sel);
    assign w_mask       = w_sel_info[5:0];
    assign w_commit_ok  = (r_state == COMMIT) && w_pat_valid && w_sel_info[6];
    assign w_commit_bad = (r_state == COMMIT) && !(w_pat_valid && w_sel_info[6]);

    // Shadow and seen values after writing the candidate into every selected digit.
    always_comb begin
        w_shadow_nx = r_shadow;
        w_dp_nx     = r_dp_shadow;
        w_seen_nx   = r_seen | w_mask;
        for (int i = 0; i < 6; i++) begin
            if (w_mask[i]) begin
                w_shadow_nx[i] = w_nibble;
                w_dp_nx[i]     = ~r_cand.led[7];
            end
        end
    end

    // Commit into shadows; publish the frame on the same edge all six are seen.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_shadow     <= '0;
            r_dp_shadow  <= '0;
            r_seen       <= '0;
            r_data_out   <= '0;
            r_dp_out     <= '0;
            r_data_valid <= 1'b0;
            r_decode_err <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            r_decode_err <= w_commit_bad;
            if (w_commit_ok) begin
                r_shadow    <= w_shadow_nx;
                r_dp_shadow <= w_dp_nx;
                if (w_seen_nx == 6'h3F) begin
                    r_data_out   <= w_shadow_nx;
                    r_dp_out     <= w_dp_nx;
                    r_data_valid <= 1'b1;
                    r_seen       <= '0;
                end else begin
                    r_seen <= w_seen_nx;
                end
            end
        end
    end

    assign data_out   = r_data_out;
    assign dp_out     = r_dp_out;
    assign data_valid = r_data_valid;
    assign decode_err = r_decode_err;

`ifdef SEG_CAPTURE_ERR_CNT_EN
    logic [7:0] r_err_cnt;

    // Saturating count of illegal commits.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst)                               r_err_cnt <= '0;
        else if (r_decode_err && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
    end

    assign err_cnt = r_err_cnt;
`endif

endmodule

// File: doc/seg_led_capture.md
Name: seg_led_capture

Overview:
- Receive-side companion to the six-digit seven-segment driver.
- Samples the segment bus (seg_sel, seg_led), filters out glitches and scan transitions, and decodes each active-low segment pattern back to a hex nibble and a decimal-point bit.
- Assembles a 24-bit display value and pulses data_valid once all six digits are captured.
- Used for on-board loopback self-check and as a bus monitor in system benches.

Parameters:
- STABLE_CYCLES, 4: consecutive sampled cycles a (seg_sel, seg_led) pair must hold before it is committed. Legal range 2..65535.
- CNT_W, 16: width of the stability counter. Must satisfy 2**CNT_W > STABLE_CYCLES.

Ports:
- sys_clk, input, 1: system clock.
- sys_rst, input, 1: asynchronous reset, active-high.
- seg_sel, input, 6: digit select, active-low. Bit i low selects digit i. 6'h00 means static mode (all digits lit); 6'h3F means blank.
- seg_led, input, 8: segments, active-low. Bit 7 is dp; bits 6..0 are g..a.
- data_out, output, 24: captured value; digit i sits in bits [4i+3:4i].
- dp_out, output, 6: captured dp per digit, active-high.
- data_valid, output, 1: one-cycle pulse when data_out/dp_out update.
- decode_err, output, 1: one-cycle pulse when a committed pair is illegal.

Behaviour:
- Reset: all outputs 0; internal sample, candidate, counter, shadow registers and seen mask all 0; state IDLE. Reset asserted mid-frame discards partial captures.
- Input stage: seg_sel/seg_led registered once into a sample pair. There is no synchroniser; inputs are in the sys_clk domain.
- FSM states:
  - IDLE: if sample sel == 6'h3F, stay. Otherwise load candidate = sample, cnt = 1, go to FILTER.
  - FILTER: if sample != candidate, go to IDLE when the sample is blank; otherwise reload candidate, cnt = 1, stay in FILTER. If sample == candidate and cnt == STABLE_CYCLES-1, go to COMMIT; else cnt++.
  - COMMIT (exactly one cycle): decode the candidate, then go to HOLD.
  - HOLD: stay while sample == candidate, so one stable pattern commits only once. On change, go to IDLE if the sample is blank, else to FILTER with the new candidate and cnt = 1.
- Commit rules:
  - Pattern: led[6:0] must match one of the 16 hex codes (0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8 8:80 9:90 A:88 B:83 C:C6 D:A1 E:86 F:8E, upper bit masked). Any other pattern is invalid.
  - Select: exactly one bit low gives digit index = that bit. 6'h00 selects all six digits. Any other multi-low value is invalid.
  - Valid: write the nibble to shadow[i] and ~led[7] to dp_shadow[i] for each selected digit; set seen[i].
  - Invalid: decode_err = 1 for one cycle; shadow and seen unchanged.
- Frame: when seen becomes 6'h3F, the same edge copies the shadows to data_out/dp_out, pulses data_valid and clears seen. Static mode therefore completes a frame in a single commit.
- Latency: input stable before edge 1 → data_valid high after edge STABLE_CYCLES+2 (edge 6 at default).
- Re-selecting an already-seen digit before the frame completes overwrites shadow[i]; this is not an error.
- data_out holds between frames.

Optional Feature:
- SEG_CAPTURE_ERR_CNT_EN defined: extra output err_cnt[7:0], reset 0. Increments on every decode_err pulse and saturates at 8'hFF.
- Not defined: no port, no counter logic.

Decomposition:
- Package seg_pkg:
  - 16 active-low segment code constants.
  - SEL_STATIC = 6'h00, SEL_BLANK = 6'h3F.
  - FSM state enum {IDLE, FILTER, COMMIT, HOLD}.
- Sub-module seg_pattern_dec: combinational, 7-bit pattern → {valid, nibble[3:0]}. Instanced once on the candidate.

Test Plan:
- Static: sel = 00, led = F9 held 10 cycles → data_out 24'h111111, dp_out 0, single data_valid at edge 6, no further pulses.
- Scan: sel 3E/3D/3B/37/2F/1F with led F9/A4/B0/99/92/82, each held 6 cycles → one data_valid with data_out 24'h654321.
- Glitch: pair held STABLE_CYCLES-1 sampled cycles, then blank → no commit, no data_valid, seen unchanged.
- Errors: sel 3E, led FF held 6 cycles → one decode_err pulse. sel 3C, led C0 held 6 cycles → one decode_err pulse. A following valid static 8E still yields 24'hFFFFFF. With the macro defined, err_cnt = 2.
- DP: sel = 00, led = 0x40 (0 with dp lit) → data_out 0, dp_out 6'h3F.
- Reset mid-scan: after three digits are captured, pulse sys_rst → all outputs 0; the next full scan needs all six digits before data_valid.
